// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-cycle data-memory port between the CPU
// load/store path and the UART memory-access port. Round-robin arbitration,
// one access per cycle, latched request fields so the memory side stays
// stable even if a requester changes its inputs after being granted.

module dmem_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          i_clk,
    input  logic          i_reset,

    // CPU load/store port
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [DW-1:0] i_cpu_wdata,
    output logic [DW-1:0] o_cpu_rdata,
    output logic          o_cpu_ack,
    output logic          o_cpu_stall,

    // UART memory-access port
    input  logic          i_uart_req,
    input  logic          i_uart_we,
    input  logic [AW-1:0] i_uart_addr,
    input  logic [DW-1:0] i_uart_wdata,
    output logic [DW-1:0] o_uart_rdata,
    output logic          o_uart_ack,

    // Shared memory port (memory read data is combinational)
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic [DW-1:0] i_mem_rdata
);

    // Requester indices into the per-port vectors below.
    localparam int NREQ     = 2;
    localparam int REQ_CPU  = 0;
    localparam int REQ_UART = 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACC_CPU  = 2'd1,
        ST_ACC_UART = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    // Last requester served: 0 = CPU, 1 = UART. Resets to UART so the CPU
    // wins the first tie after reset.
    logic            r_last;

    // Access fields captured at the grant edge; the memory side is driven
    // only from these.
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;

    // Per-requester views of the two ports.
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_we_in;
    logic [AW-1:0]   w_addr_in  [NREQ];
    logic [DW-1:0]   w_wdata_in [NREQ];
    logic [NREQ-1:0] w_acking;
    logic [NREQ-1:0] w_cand;
    logic [NREQ-1:0] w_grant;
    logic            w_any_grant;
    logic            w_win_uart;
    logic            w_in_access;

    assign w_req[REQ_CPU]         = i_cpu_req;
    assign w_req[REQ_UART]        = i_uart_req;
    assign w_we_in[REQ_CPU]       = i_cpu_we;
    assign w_we_in[REQ_UART]      = i_uart_we;
    assign w_addr_in[REQ_CPU]     = i_cpu_addr;
    assign w_addr_in[REQ_UART]    = i_uart_addr;
    assign w_wdata_in[REQ_CPU]    = i_cpu_wdata;
    assign w_wdata_in[REQ_UART]   = i_uart_wdata;

    // A requester is being acknowledged exactly while its ACC state is active.
    assign w_acking[REQ_CPU]      = (r_state == ST_ACC_CPU);
    assign w_acking[REQ_UART]     = (r_state == ST_ACC_UART);
    assign w_in_access            = |w_acking;

    // A requester whose ack is high this cycle is excluded from the edge that
    // ends the cycle; if it still holds req, that counts as a fresh request
    // competing at the following edge. This is what makes continuous
    // contention alternate without idle cycles.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_cand
            assign w_cand[gi] = w_req[gi] & ~w_acking[gi];
        end
    endgenerate

    // Round-robin: a lone candidate always wins; on a tie the requester that
    // was not served last wins. A tie can only occur from IDLE, since in an
    // ACC state one of the two is always excluded.
    assign w_grant[REQ_CPU]  = w_cand[REQ_CPU]  & (~w_cand[REQ_UART] |  r_last);
    assign w_grant[REQ_UART] = w_cand[REQ_UART] & (~w_cand[REQ_CPU]  | ~r_last);
    assign w_any_grant       = |w_grant;
    assign w_win_uart        = w_grant[REQ_UART];

    // State register: reset aborts any access in flight immediately.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: the winner (if any) gets the next cycle; otherwise idle.
    always_comb begin
        w_state_next = ST_IDLE;
        if (w_grant[REQ_CPU]) begin
            w_state_next = ST_ACC_CPU;
        end else if (w_grant[REQ_UART]) begin
            w_state_next = ST_ACC_UART;
        end
    end

    // Capture the winner's access fields and remember who was served.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_any_grant) begin
            r_last  <= w_win_uart;
            r_we    <= w_we_in[w_win_uart];
            r_addr  <= w_addr_in[w_win_uart];
            r_wdata <= w_wdata_in[w_win_uart];
        end
    end

    // Output logic: memory side from latched fields, acks from state, read
    // data passed straight through while the matching ack is high. Address
    // and write data keep their last latched values when idle; only the
    // write enable is gated by the access state.
    always_comb begin
        o_cpu_ack    = w_acking[REQ_CPU];
        o_uart_ack   = w_acking[REQ_UART];
        o_cpu_stall  = i_cpu_req & ~w_acking[REQ_CPU];
        o_mem_we     = w_in_access & r_we;
        o_mem_addr   = r_addr;
        o_mem_wdata  = r_wdata;
        o_cpu_rdata  = w_acking[REQ_CPU]  ? i_mem_rdata : '0;
        o_uart_rdata = w_acking[REQ_UART] ? i_mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: a small word-addressed memory model sits on the
// memory port; expected transactions are queued per requester when a request
// is driven and popped when the matching ack appears.

module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req, cpu_we, uart_req, uart_we;
    logic [AW-1:0] cpu_addr, uart_addr;
    logic [DW-1:0] cpu_wdata, uart_wdata;
    logic [DW-1:0] cpu_rdata, uart_rdata;
    logic          cpu_ack, cpu_stall, uart_ack;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          t_req;
    } txn_t;

    txn_t cpu_q[$];
    txn_t uart_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] mem [0:1023];

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_ack    (cpu_ack),
        .o_cpu_stall  (cpu_stall),
        .i_uart_req   (uart_req),
        .i_uart_we    (uart_we),
        .i_uart_addr  (uart_addr),
        .i_uart_wdata (uart_wdata),
        .o_uart_rdata (uart_rdata),
        .o_uart_ack   (uart_ack),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .i_mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Memory model: captures on the edge that ends a write access.
    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_addr[11:2]] = mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[11:2]];

    function automatic logic [31:0] pat(input int idx);
        return 32'hA500_0000 | 32'(idx);
    endfunction

    task automatic test_reset();
        @(negedge clk);
        cpu_req = 1'b1;
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL rst_stall: got %b want 1", cpu_stall); end
        n_cmp++; if (cpu_ack !== 1'b0 || uart_ack !== 1'b0) begin n_bad++; $display("FAIL rst_acks: got %b%b want 00", cpu_ack, uart_ack); end
        n_cmp++; if (mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_mem: got we=%b a=%h d=%h want 0/0/0", mem_we, mem_addr, mem_wdata); end
        cpu_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        // Start a store and abort it with reset in the middle of the access.
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1111_2222;
        @(negedge clk);
        n_cmp++; if (cpu_ack !== 1'b1 || mem_we !== 1'b1) begin n_bad++; $display("FAIL pre_abort_ack: got ack=%b we=%b want 1/1", cpu_ack, mem_we); end
        #1 reset = 1'b1;
        #1;
        n_cmp++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL abort_now: got ack=%b we=%b want 0/0", cpu_ack, mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL abort_addr: got %h want 0", mem_addr); end
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (cpu_ack !== 1'b0 || uart_ack !== 1'b0 || mem_we !== 1'b0 || cpu_stall !== 1'b0 ||
                mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                n_bad++;
                $display("FAIL idle_after_rst: got ack=%b%b we=%b st=%b a=%h d=%h want all 0",
                         cpu_ack, uart_ack, mem_we, cpu_stall, mem_addr, mem_wdata);
            end
        end
        n_cmp++; if (mem[4] !== pat(4)) begin n_bad++; $display("FAIL abort_no_write: got %h want %h", mem[4], pat(4)); end
        $display("txn reset: abort of CPU store to 0x10 checked");
    endtask

    task automatic test_cpu_store();
        txn_t e;
        bit   done = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hDEAD_BEEF;
        cpu_q.push_back('{1'b1, 32'h40, 32'hDEAD_BEEF, cyc});
        #1;
        n_cmp++; if (cpu_stall !== 1'b1) begin n_bad++; $display("FAIL store_stall_req: got %b want 1", cpu_stall); end
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                e = cpu_q.pop_front();
                n_cmp++; if (mem_we !== e.we || mem_addr !== e.addr || mem_wdata !== e.data) begin n_bad++; $display("FAIL store_mem: got we=%b a=%h d=%h want %b/%h/%h", mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data); end
                n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL store_stall_ack: got %b want 0", cpu_stall); end
                n_cmp++; if (cyc - e.t_req != 1) begin n_bad++; $display("FAIL store_latency: got %0d want 1", cyc - e.t_req); end
                $display("txn cpu store a=%h d=%h", e.addr, e.data);
                cpu_req = 1'b0; cpu_we = 1'b0;
                done = 1;
            end
        end
        if (!done) begin n_cmp++; n_bad++; $display("FAIL store_timeout: got no cpu_ack want ack within 4 cycles"); end
        @(negedge clk);
        n_cmp++; if (cpu_ack !== 1'b0 || mem_we !== 1'b0) begin n_bad++; $display("FAIL store_one_pulse: got ack=%b we=%b want 0/0", cpu_ack, mem_we); end
        n_cmp++; if (mem[16] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL store_landed: got %h want deadbeef", mem[16]); end
    endtask

    task automatic test_uart_load();
        txn_t e;
        bit   done = 0;
        @(negedge clk);
        uart_req = 1'b1; uart_we = 1'b0; uart_addr = 32'h44; uart_wdata = 32'hFFFF_FFFF;
        uart_q.push_back('{1'b0, 32'h44, 32'h1234_5678, cyc});
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge clk);
            if (uart_ack === 1'b1) begin
                e = uart_q.pop_front();
                n_cmp++; if (uart_rdata !== e.data) begin n_bad++; $display("FAIL load_rdata: got %h want %h", uart_rdata, e.data); end
                n_cmp++; if (mem_we !== 1'b0 || mem_addr !== e.addr) begin n_bad++; $display("FAIL load_mem: got we=%b a=%h want 0/%h", mem_we, mem_addr, e.addr); end
                n_cmp++; if (cyc - e.t_req != 1 || cpu_ack !== 1'b0) begin n_bad++; $display("FAIL load_latency: got %0d cpu_ack=%b want 1/0", cyc - e.t_req, cpu_ack); end
                $display("txn uart load a=%h d=%h", e.addr, uart_rdata);
                uart_req = 1'b0;
                done = 1;
            end
        end
        if (!done) begin n_cmp++; n_bad++; $display("FAIL load_timeout: got no uart_ack want ack within 4 cycles"); end
    endtask

    task automatic test_simultaneous();
        txn_t e;
        int   cpu_n = 0, uart_n = 0, cpu_at = -1, uart_at = -1;
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        cpu_req  = 1'b1; cpu_we  = 1'b0; cpu_addr  = 32'h208; cpu_wdata  = 32'h0;
        uart_req = 1'b1; uart_we = 1'b1; uart_addr = 32'h50;  uart_wdata = 32'h5A5A_0001;
        cpu_q.push_back('{1'b0, 32'h208, pat(32'h82), cyc});
        uart_q.push_back('{1'b1, 32'h50, 32'h5A5A_0001, cyc});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1 && cpu_q.size() > 0) begin
                e = cpu_q.pop_front();
                cpu_n++; cpu_at = cyc;
                n_cmp++; if (cpu_rdata !== e.data || mem_addr !== e.addr || mem_we !== 1'b0) begin n_bad++; $display("FAIL sim_cpu: got d=%h a=%h we=%b want %h/%h/0", cpu_rdata, mem_addr, mem_we, e.data, e.addr); end
                $display("txn cpu load a=%h d=%h", e.addr, cpu_rdata);
                cpu_req = 1'b0;
            end else if (cpu_ack === 1'b1) begin
                cpu_n++;
            end
            if (uart_ack === 1'b1 && uart_q.size() > 0) begin
                e = uart_q.pop_front();
                uart_n++; uart_at = cyc;
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin n_bad++; $display("FAIL sim_uart: got we=%b a=%h d=%h want 1/%h/%h", mem_we, mem_addr, mem_wdata, e.addr, e.data); end
                $display("txn uart store a=%h d=%h", e.addr, e.data);
                uart_req = 1'b0;
            end else if (uart_ack === 1'b1) begin
                uart_n++;
            end
        end
        n_cmp++; if (cpu_n != 1 || uart_n != 1) begin n_bad++; $display("FAIL sim_ack_count: got cpu=%0d uart=%0d want 1/1", cpu_n, uart_n); end
        n_cmp++; if (uart_at != cpu_at + 1 || cpu_at < 0) begin n_bad++; $display("FAIL sim_order: got cpu@%0d uart@%0d want uart one cycle after cpu", cpu_at, uart_at); end
        n_cmp++; if (mem[20] !== 32'h5A5A_0001) begin n_bad++; $display("FAIL sim_store_landed: got %h want 5a5a0001", mem[20]); end
    endtask

    task automatic test_contention();
        txn_t e;
        int   cpu_iss = 0, uart_iss = 0, cpu_n = 0, uart_n = 0;
        int   first_at = -1, last_at = -1, prev = -1;
        @(negedge clk);
        cpu_req  = 1'b1; cpu_we  = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hC0DE_0000;
        cpu_q.push_back('{1'b1, 32'h100, 32'hC0DE_0000, cyc}); cpu_iss = 1;
        uart_req = 1'b1; uart_we = 1'b0; uart_addr = 32'h300;
        uart_q.push_back('{1'b0, 32'h300, pat(32'hC0), cyc}); uart_iss = 1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1 && uart_ack === 1'b1) begin n_cmp++; n_bad++; $display("FAIL cont_both_ack: got 11 want one ack"); end
            if (cpu_ack === 1'b1 && cpu_q.size() > 0) begin
                e = cpu_q.pop_front();
                cpu_n++; last_at = cyc; if (first_at < 0) first_at = cyc;
                n_cmp++; if (mem_we !== 1'b1 || mem_addr !== e.addr || mem_wdata !== e.data) begin n_bad++; $display("FAIL cont_cpu_mem: got we=%b a=%h d=%h want 1/%h/%h", mem_we, mem_addr, mem_wdata, e.addr, e.data); end
                n_cmp++; if (cyc - e.t_req > 2 || cyc - e.t_req < 1) begin n_bad++; $display("FAIL cont_cpu_wait: got %0d want 1..2", cyc - e.t_req); end
                n_cmp++; if (prev == 0) begin n_bad++; $display("FAIL cont_alternate: got cpu twice want uart"); end
                prev = 0;
                $display("txn cpu store a=%h d=%h", e.addr, e.data);
                if (cpu_iss < 4) begin
                    cpu_addr = 32'h100 + 32'(4 * cpu_iss); cpu_wdata = 32'hC0DE_0000 + 32'(cpu_iss);
                    cpu_q.push_back('{1'b1, cpu_addr, cpu_wdata, cyc}); cpu_iss++;
                end else begin
                    cpu_req = 1'b0;
                end
            end
            if (uart_ack === 1'b1 && uart_q.size() > 0) begin
                e = uart_q.pop_front();
                uart_n++; last_at = cyc; if (first_at < 0) first_at = cyc;
                n_cmp++; if (uart_rdata !== e.data || mem_addr !== e.addr || mem_we !== 1'b0) begin n_bad++; $display("FAIL cont_uart_load: got d=%h a=%h we=%b want %h/%h/0", uart_rdata, mem_addr, mem_we, e.data, e.addr); end
                n_cmp++; if (cyc - e.t_req > 2 || cyc - e.t_req < 1) begin n_bad++; $display("FAIL cont_uart_wait: got %0d want 1..2", cyc - e.t_req); end
                n_cmp++; if (prev == 1) begin n_bad++; $display("FAIL cont_alternate: got uart twice want cpu"); end
                prev = 1;
                $display("txn uart load a=%h d=%h", e.addr, uart_rdata);
                if (uart_iss < 4) begin
                    uart_addr = 32'h300 + 32'(4 * uart_iss);
                    uart_q.push_back('{1'b0, uart_addr, pat(32'hC0 + uart_iss), cyc}); uart_iss++;
                end else begin
                    uart_req = 1'b0;
                end
            end
        end
        n_cmp++; if (cpu_n != 4 || uart_n != 4) begin n_bad++; $display("FAIL cont_counts: got cpu=%0d uart=%0d want 4/4", cpu_n, uart_n); end
        n_cmp++; if (last_at - first_at != 7) begin n_bad++; $display("FAIL cont_no_gap: got span %0d want 7", last_at - first_at); end
        for (int n = 0; n < 4; n++) begin
            n_cmp++; if (mem[64 + n] !== 32'hC0DE_0000 + 32'(n)) begin n_bad++; $display("FAIL cont_store_%0d: got %h want %h", n, mem[64 + n], 32'hC0DE_0000 + 32'(n)); end
        end
        cpu_q.delete(); uart_q.delete();
    endtask

    task automatic test_input_change();
        txn_t e;
        bit   done = 0;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFE_F00D;
        cpu_q.push_back('{1'b1, 32'h40, 32'hCAFE_F00D, cyc});
        for (int k = 0; k < 4 && !done; k++) begin
            @(negedge clk);
            if (cpu_ack === 1'b1) begin
                e = cpu_q.pop_front();
                cpu_addr = 32'h80; cpu_wdata = 32'h0BAD_BAD0;
                #1;
                n_cmp++; if (mem_addr !== e.addr || mem_wdata !== e.data || mem_we !== 1'b1) begin n_bad++; $display("FAIL chg_stable: got a=%h d=%h we=%b want %h/%h/1", mem_addr, mem_wdata, mem_we, e.addr, e.data); end
                $display("txn cpu store a=%h d=%h (inputs changed after grant)", e.addr, e.data);
                cpu_req = 1'b0;
                done = 1;
            end
        end
        if (!done) begin n_cmp++; n_bad++; $display("FAIL chg_timeout: got no cpu_ack want ack within 4 cycles"); end
        @(negedge clk);
        n_cmp++; if (mem[16] !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL chg_landed: got %h want cafef00d", mem[16]); end
        n_cmp++; if (mem[32] !== pat(32)) begin n_bad++; $display("FAIL chg_untouched: got %h want %h", mem[32], pat(32)); end
    endtask

    initial begin
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        uart_req = 1'b0; uart_we = 1'b0; uart_addr = '0; uart_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        mem[17] = 32'h1234_5678;
        test_reset();
        test_cpu_store();
        test_uart_load();
        test_simultaneous();
        test_contention();
        test_input_change();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion want finish before 100000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single data-memory port between the processor load/store path and the UART peripheral's memory-access port. Each requester holds a request until it is acknowledged. The block grants one access per cycle using round-robin arbitration and drives a one-cycle access on the memory. It also produces the stall the processor datapath uses to freeze the PC while a CPU access waits for its grant.

## Interface
- AW, 32, address width
- DW, 32, data width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ack
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  CPU byte address
- cpu_wdata  in  DW  CPU store data
- cpu_rdata  out  DW  load data, valid while cpu_ack=1
- cpu_ack  out  1  one-cycle completion pulse
- cpu_stall  out  1  cpu_req & ~cpu_ack
- uart_req, uart_we, uart_addr, uart_wdata  in  1/1/AW/DW  UART port, same rules as the CPU port
- uart_rdata  out  DW  load data, valid while uart_ack=1
- uart_ack  out  1  one-cycle completion pulse
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  combinational read data from memory

## Operation
- States: IDLE, ACC_CPU, ACC_UART.
- Registers: state; last (0 = CPU last served, 1 = UART); latched we/addr/wdata.
- Arbitration happens at a rising edge in any state. Candidates are the requesters with req=1 that are not being acknowledged in the current cycle.
  - One candidate: it wins.
  - Two candidates: it cannot happen that both are eligible while one is being acked, so this applies only from IDLE. The requester not equal to `last` wins.
  - No candidate: next state is IDLE.
- On a win:
  - The winner's we/addr/wdata are latched.
  - The next state is ACC_CPU or ACC_UART.
  - `last` is updated to the winner.
- Both ACC states:
  - mem_addr, mem_wdata and mem_we are driven from the latched values, so they stay stable even if the requester's inputs change.
  - The matching ack is 1.
  - The matching rdata equals mem_rdata.
- Outside the ACC states: mem_we=0, and mem_addr and mem_wdata hold their last latched values.
- Back-to-back behaviour:
  - From ACC_CPU with uart_req=1, the next state is ACC_UART, with no IDLE bubble.
  - A requester whose ack is high in the current cycle is not re-granted at that edge. If it still holds req afterwards, that is a new request and it competes at the next edge.
- Requester protocol:
  - req must stay 1 until ack. Any change to we/addr/wdata after the grant edge is ignored.
  - Dropping req before ack is a protocol violation. The latched access still completes and still pulses ack.
- Both rdata outputs are combinational pass-throughs of mem_rdata, qualified only by ack. They are don't-care when ack=0.

## Timing
- Reset, asynchronous, applies immediately:
  - state=IDLE, last=1 (CPU wins the first tie)
  - latched we/addr/wdata = 0
  - cpu_ack=0, uart_ack=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_stall follows cpu_req
- Reset in the middle of an access aborts it. No ack pulses and mem_we drops at once. The requester must re-request after reset releases.
- Latency:
  - Request seen at edge k gives the access and ack in cycle k+1 (one cycle after the request).
  - A loser that keeps requesting is served in the cycle after the winner's access.
- Worst-case wait is 2 cycles from request to ack under continuous contention.
- Throughput is one access per cycle with no idle cycles when requests are continuous.
- Writes:
  - mem_we is high for exactly one cycle per store.
  - Memory captures on the rising edge that ends the ACC state.
- Loads: read data is combinational within the ACC cycle. The requester samples it at the edge that ends that cycle.
- cpu_stall is combinational, so it is 1 in the request cycle and 0 in the ack cycle.

## Test plan
- Reset check: assert reset mid-ACC_CPU with cpu_we=1 → cpu_ack=0 and mem_we=0 immediately. After release with no requests, the block stays IDLE with all outputs 0.
- Single CPU store: cpu_req=1, cpu_we=1, addr=0x40, wdata=0xDEADBEEF → next cycle mem_we=1, mem_addr=0x40, mem_wdata=0xDEADBEEF, cpu_ack=1. cpu_stall=1 for exactly 1 cycle.
- Single UART load: addr=0x44, memory holds 0x12345678 → uart_ack=1 one cycle later, uart_rdata=0x12345678, mem_we=0.
- Simultaneous requests from reset: both req=1 with distinct addresses → ACC_CPU, then ACC_UART in the next cycle. Each ack pulses once and there is no IDLE gap.
- Continuous contention for 8 cycles: both keep re-requesting → grants alternate CPU/UART, 4 acks each, and every wait is ≤2 cycles.
- Input change after grant: change cpu_addr from 0x40 to 0x80 in the ACC_CPU cycle → mem_addr stays 0x40 and the store lands at 0x40.
